// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter: latches a word, presents {parity, data} in parallel and
// shifts a start/data(LSB first)/parity/stop frame out on tx_line, CLKS_PER_BIT cycles per bit.
module odd_parity_serial_tx #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W:0]   code_out,
  output logic              par_out,
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_valid seen while a frame is in flight is ignored, so upstream must hold it.

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W:0]   code_q, code_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end = (clk_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      code_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      code_q    <= code_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    code_d    = code_q;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (in_valid) begin
          state_d = S_START;
          shift_d = in_data;
          code_d  = {~(^in_data), in_data};
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          clk_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          clk_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Line level is chosen from the state being entered so tx_line stays a pure flop output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = code_d[DATA_W];
      default:  tx_d = 1'b1;
    endcase
  end

  assign in_ready = rst_n && (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_STOP) && bit_end;
  assign code_out = code_q;
  assign par_out  = code_q[DATA_W];
  assign tx_line  = tx_q;

endmodule

// File: doc/odd_parity_serial_tx.md
Name: odd_parity_serial_tx

Overview:
- Transmit-side counterpart to the 4-bit odd parity checker.
- Accepts a DATA_W-bit word via a valid/ready handshake and computes the odd parity bit, so that data plus parity contains an odd number of ones.
- Presents the (DATA_W+1)-bit codeword in parallel for the checker and shifts it out serially as a framed bitstream: start, data LSB-first, parity, stop.
- With the default DATA_W=3, the codeword is the 4-bit word the odd parity checker consumes.

Parameters:
- DATA_W, 3, data bits per word; codeword width is DATA_W+1.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range is 1 or more.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; equals (state==IDLE).
- code_out  output  DATA_W+1  registered codeword {parity, data}; parity is the MSB.
- par_out  output  1  registered parity bit, equal to code_out[DATA_W].
- tx_line  output  1  serial output; idles high.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, tx_line=1, code_out=0, par_out=0, busy=0, done=0, bit and clock counters=0. in_ready=1 once rst_n deasserts.
- Parity rule: par = ~(XOR of all in_data bits). Any codeword {par, data} then has odd weight, and the checker's even-error output reads 0.
- Accept: on a clock edge with state==IDLE and in_valid=1, capture in_data into a shift register and load code_out/par_out. Next state is START.
  - in_valid while not IDLE is ignored; the upstream side must hold it.
- States and the level driven on tx_line:
  - IDLE: tx_line=1.
  - START: tx_line=0 for CLKS_PER_BIT cycles.
  - DATA: tx_line = shift_reg[0]; shift right each bit period. DATA_W bit periods, LSB first. A bit counter runs 0..DATA_W-1.
  - PARITY: tx_line=par for CLKS_PER_BIT cycles.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles; done=1 in its last cycle, then go to IDLE.
- Timing:
  - tx_line is registered. The start bit appears in the cycle after the accept edge.
  - Frame length is (DATA_W+3)*CLKS_PER_BIT cycles, counted from the first start-bit cycle through the last stop cycle.
- Back-to-back: at least one IDLE cycle separates frames, with tx_line=1 during it. The earliest next accept is the edge that ends that IDLE cycle.
- Hold: code_out and par_out keep the last word until the next accept. They do not clear at frame end.
- Clock counter: width $clog2(CLKS_PER_BIT) with a minimum of 1. It counts 0..CLKS_PER_BIT-1 and is reset on every state/bit transition.
  - CLKS_PER_BIT=1 must produce exactly one cycle per bit.
- Reset mid-frame: tx_line goes to 1 immediately. The frame is abandoned with no done pulse. After release the block is in IDLE with in_ready=1.
- No X on any output after reset for any in_data value.

Test Plan:
- Reset: with rst_n=0 and random inputs, expect tx_line=1, busy=0, done=0, in_ready=0→1 after release, code_out=4'b0000.
- Accept in_data=3'b000 with CLKS_PER_BIT=4:
  - code_out=4'b1000 and par_out=1 from the cycle after the accept edge.
  - tx_line sequence, 4 cycles each: 0,0,0,0,1,1 (24 cycles).
  - done pulses once in cycle 24.
- Parity values: in_data=3'b101 → code_out=4'b1101, serial bits 0,1,0,1,1,1. in_data=3'b111 → code_out=4'b0111, serial bits 0,1,1,1,0,1.
  - Feeding each code_out into the odd parity checker gives e=0 for all 8 inputs.
- Handshake: hold in_valid=1 continuously with words 3'b011 then 3'b110.
  - Second accept occurs exactly (DATA_W+3)*CLKS_PER_BIT+1 cycles after the first.
  - One idle-high cycle between frames; the second word's parity bit is 1.
  - in_valid pulsed mid-frame is ignored.
- Reset mid-frame: assert rst_n=0 during a DATA bit. Expect tx_line=1 asynchronously, no done pulse, busy=0. A fresh frame for 3'b001 then transmits 0,1,0,0,0,1.
- Rebuild with CLKS_PER_BIT=1: frame for 3'b010 is 0,0,1,0,0,1 over 6 consecutive cycles, done in cycle 6.
